// File: rtl/aud_time_counter.sv
// Elapsed-seconds tracker for record/playback sessions with BCD digit outputs.
// Define AUD_TIME_BLINK_EN to build the half-second pause blink on o_blank.
module aud_time_counter #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int MAX_SEC = 99
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  output logic [6:0] o_time,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_running,
  output logic       o_paused,
  output logic       o_full,
  output logic       o_blank
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [6:0]    count, count_n;
  logic          full, full_n;
  logic          adv;

  // start outranks pause, so a start in RUN keeps counting
  assign adv = !i_stop && (i_start || !i_pause);

  always_comb begin
    state_n = state;
    presc_n = presc;
    count_n = count;
    full_n  = full;
    unique case (state)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_n = RUN;
          presc_n = '0;
          count_n = '0;
          full_n  = 1'b0;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (!adv) begin
          state_n = PAUSE;
        end else if (presc == PW'(CLK_HZ - 1)) begin
          presc_n = '0;
          if (count < 7'(MAX_SEC)) count_n = count + 7'd1;
          else                     full_n  = 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (i_stop)                  state_n = IDLE;
        else if (i_start || i_pause) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      presc     <= '0;
      count     <= '0;
      full      <= 1'b0;
      o_tens    <= '0;
      o_ones    <= '0;
      o_running <= 1'b0;
      o_paused  <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      count     <= count_n;
      full      <= full_n;
      o_tens    <= 4'(count_n / 7'd10);
      o_ones    <= 4'(count_n % 7'd10);
      o_running <= (state_n == RUN);
      o_paused  <= (state_n == PAUSE);
    end
  end

  assign o_time = count;
  assign o_full = full;

`ifdef AUD_TIME_BLINK_EN
  logic [PW-1:0] bcnt;
  logic          blank;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcnt  <= '0;
      blank <= 1'b0;
    end else if (state == PAUSE && state_n == PAUSE) begin
      if (bcnt == PW'(CLK_HZ / 2 - 1)) begin
        bcnt  <= '0;
        blank <= ~blank;
      end else begin
        bcnt  <= bcnt + 1'b1;
      end
    end else begin
      // covers PAUSE entry as well as IDLE/RUN
      bcnt  <= '0;
      blank <= 1'b0;
    end
  end

  assign o_blank = blank;
`else
  assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_aud_time_counter.sv
// Bench for aud_time_counter: directed scenarios then random key pulses,
// checked every cycle against a run-cycle-count reference model.
module tb_aud_time_counter;

  localparam int HZ = 10;
  localparam int MX = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] o_time;
  logic [3:0] tens, ones;
  logic       running, paused, full, blank;

  int compared = 0;
  int mismatched = 0;

  // model: mode 0 idle / 1 run / 2 pause; n = advancing run cycles; pc = pause cycles
  int mode = 0;
  int n = 0;
  int pc = 0;

  always #5 clk = ~clk;

  aud_time_counter #(.CLK_HZ(HZ), .MAX_SEC(MX)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_pause(pause),
    .i_stop(stop),
    .o_time(o_time),
    .o_tens(tens),
    .o_ones(ones),
    .o_running(running),
    .o_paused(paused),
    .o_full(full),
    .o_blank(blank)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sec, et, eb;
    sec = n / HZ;
    et  = (sec > MX) ? MX : sec;
`ifdef AUD_TIME_BLINK_EN
    eb = (mode == 2) ? (pc / (HZ / 2)) % 2 : 0;
`else
    eb = 0;
`endif
    check("time", 32'(o_time), 32'(et));
    check("tens", 32'(tens), 32'(et / 10));
    check("ones", 32'(ones), 32'(et % 10));
    check("running", 32'(running), 32'(mode == 1));
    check("paused", 32'(paused), 32'(mode == 2));
    check("full", 32'(full), 32'(sec > MX));
    check("blank", 32'(blank), 32'(eb));
  endtask

  task automatic step(input logic r, input logic s, input logic p,
                      input logic t);
    rst = r;
    start = s;
    pause = p;
    stop = t;
    @(posedge clk);
    if (r) begin
      mode = 0; n = 0; pc = 0;
    end else begin
      case (mode)
        0: if (s && !t) begin mode = 1; n = 0; end
        1: if (t) mode = 0;
           else if (s || !p) n++;
           else begin mode = 2; pc = 0; end
        default: if (t) mode = 0;
                 else if (s || p) mode = 1;
                 else pc++;
      endcase
    end
    #1;
    rst = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset with pulses overlapping
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_time", 32'(o_time), 32'd0);

    // 35 cycles of RUN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(35);
    check("run35_time", 32'(o_time), 32'd3);
    check("run35_ones", 32'(ones), 32'd3);

    // pause mid-second then resume
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(25);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(100);
    check("pause_time", 32'(o_time), 32'd2);
    check("pause_flag", 32'(paused), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("resume4_time", 32'(o_time), 32'd2);
    idle(1);
    check("resume5_time", 32'(o_time), 32'd3);

    // saturation
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(200);
    check("sat_time", 32'(o_time), 32'd12);
    check("sat_tens", 32'(tens), 32'd1);
    check("sat_full", 32'(full), 32'd1);

    // start+stop in RUN, stop on tick cycle, fresh start
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ss_time", 32'(o_time), 32'd12);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("stoptick_time", 32'(o_time), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_full", 32'(full), 32'd0);

    // long pause for blink
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(22);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // random pulses
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 14) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
